// File: rtl/pet_vidcap_pkg.sv
// Shared types and constants for the PET video capture receiver.
package pet_vidcap_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        ARMED,
        ACTIVE
    } vc_state_e;

    localparam int PET_VID_BYTES_PER_LINE = 40;
    localparam int PET_VID_AW             = 13;
    localparam int PET_VID_PXW            = 10;
    localparam int PET_VID_LNW            = 9;

    function automatic logic [PET_VID_PXW-1:0] px_inc(
        input logic [PET_VID_PXW-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [PET_VID_LNW-1:0] ln_inc(
        input logic [PET_VID_LNW-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pet_vidcap_deser.sv
// MSB-first pixel deserialiser: 8 shifts produce one registered byte strobe.
module pet_vidcap_deser (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       shift_en,
    input  logic       flush,
    input  logic       bit_in,
    output logic       byte_vld,
    output logic [7:0] byte_out
);

    logic [6:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       vld_q, vld_d;
    logic [7:0] byte_q, byte_d;

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        vld_d  = 1'b0;
        byte_d = byte_q;
        if (flush) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en) begin
            sr_d  = {sr_q[5:0], bit_in};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                vld_d  = 1'b1;
                byte_d = {sr_q, bit_in};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            vld_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            vld_q  <= vld_d;
            byte_q <= byte_d;
        end
    end

    assign byte_vld = vld_q;
    assign byte_out = byte_q;

endmodule

// File: rtl/pet_vidcap.sv
// PET video capture: drive-edge tracking, frame FSM, frame-buffer byte writes.
// Optional line/error statistics are enabled with PET_VIDCAP_STATS_EN.
module pet_vidcap
    import pet_vidcap_pkg::*;
#(
    parameter int H_BACKPORCH = 40,
    parameter int V_BACKPORCH = 20,
    parameter int ACTIVE_W    = PET_VID_BYTES_PER_LINE * 8,
    parameter int ACTIVE_H    = 200
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        video,
    input  logic        horz_drive,
    input  logic        vert_drive,
    output logic        wr_en,
    output logic [12:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_done,
    output logic        frame_err,
    output logic        locked,
    output logic [9:0]  line_len,
    output logic [7:0]  err_cnt
);

    localparam int BPL = ACTIVE_W / 8;

    vc_state_e              state_q, state_d;
    logic                   h_prev_q, h_prev_d;
    logic                   v_prev_q, v_prev_d;
    logic [PET_VID_PXW-1:0] px_q, px_d;
    logic [PET_VID_LNW-1:0] ln_q, ln_d;
    logic [PET_VID_AW-1:0]  addr_q, addr_d;
    logic                   locked_q, locked_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   h_fall, v_fall;
    logic                   cap, byte_end;
    logic [PET_VID_PXW-1:0] pix_idx, rel;
    logic [PET_VID_LNW-1:0] aline;
    logic [PET_VID_AW-1:0]  line_base;

    assign h_fall  = pix_en & h_prev_q & ~horz_drive;
    assign v_fall  = pix_en & v_prev_q & ~vert_drive;
    // Index of the pixel carried by this sample; the h_fall sample is pixel 0.
    assign pix_idx = h_fall ? '0 : px_inc(px_q);
    assign rel     = pix_idx - PET_VID_PXW'(H_BACKPORCH);
    assign aline   = ln_q - PET_VID_LNW'(V_BACKPORCH);

    assign cap = pix_en && (state_q == ACTIVE) && !v_fall && !h_fall
              && (int'(pix_idx) >= H_BACKPORCH)
              && (int'(pix_idx) < H_BACKPORCH + ACTIVE_W)
              && (int'(aline) < ACTIVE_H);

    assign byte_end  = cap && (rel[2:0] == 3'b111);
    assign line_base = PET_VID_AW'(aline) * PET_VID_AW'(BPL);

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        h_prev_d = pix_en ? horz_drive : h_prev_q;
        v_prev_d = pix_en ? vert_drive : v_prev_q;
        px_d     = pix_en ? pix_idx : px_q;
        ln_d     = ln_q;
        addr_d   = addr_q;
        done_d   = byte_end
                && (aline == PET_VID_LNW'(ACTIVE_H - 1))
                && (rel == PET_VID_PXW'(ACTIVE_W - 1));

        if (v_fall) begin
            ln_d = '0;
        end else if (h_fall) begin
            ln_d = ln_inc(ln_q);
        end

        if (byte_end) begin
            addr_d = line_base + PET_VID_AW'(rel[PET_VID_PXW-1:3]);
        end

        unique case (state_q)
            SEARCH: begin
                if (v_fall) state_d = ARMED;
            end
            ARMED: begin
                if (h_fall && !v_fall && ln_d == PET_VID_LNW'(V_BACKPORCH)) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (v_fall) begin
                    state_d  = ARMED;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                end else if (done_d) begin
                    state_d  = SEARCH;
                    locked_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= SEARCH;
            h_prev_q <= 1'b1;
            v_prev_q <= 1'b1;
            px_q     <= '0;
            ln_q     <= '0;
            addr_q   <= '0;
            locked_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_prev_q <= h_prev_d;
            v_prev_q <= v_prev_d;
            px_q     <= px_d;
            ln_q     <= ln_d;
            addr_q   <= addr_d;
            locked_q <= locked_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    pet_vidcap_deser u_deser (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (cap),
        .flush    (h_fall | v_fall | (state_q != ACTIVE)),
        .bit_in   (video),
        .byte_vld (wr_en),
        .byte_out (wr_data)
    );

    assign wr_addr    = addr_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign locked     = locked_q;

`ifdef PET_VIDCAP_STATS_EN
    logic [9:0] len_q, len_d;
    logic [7:0] ecnt_q, ecnt_d;

    always_comb begin
        len_d  = h_fall ? px_inc(px_q) : len_q;
        ecnt_d = (err_d && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            len_q  <= '0;
            ecnt_q <= '0;
        end else begin
            len_q  <= len_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign line_len = len_q;
    assign err_cnt  = ecnt_q;
`else
    assign line_len = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_pet_vidcap.sv
// Directed self-checking bench for pet_vidcap (ACTIVE_H reduced to 8 lines).
module tb_pet_vidcap;

    localparam int HB  = 40;
    localparam int VB  = 20;
    localparam int AWP = 320;
    localparam int AH  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        video = 1'b0;
    logic        horz_drive = 1'b1;
    logic        vert_drive = 1'b1;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        frame_done;
    logic        frame_err;
    logic        locked;
    logic [9:0]  line_len;
    logic [7:0]  err_cnt;

    int total = 0;
    int bad = 0;
    int writes = 0;

    always #5 clk = ~clk;

    pet_vidcap #(
        .H_BACKPORCH (HB),
        .V_BACKPORCH (VB),
        .ACTIVE_W    (AWP),
        .ACTIVE_H    (AH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_en     (pix_en),
        .video      (video),
        .horz_drive (horz_drive),
        .vert_drive (vert_drive),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .locked     (locked),
        .line_len   (line_len),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 1: lit only px 40..47; mode 2: 1,0,1,0 from px 40; mode 3: all lit
    function automatic logic vid(input int mode, input int k);
        case (mode)
            1: return (k >= HB) && (k < HB + 8);
            2: return (k >= HB) && ((k - HB) % 2 == 0);
            3: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(input int mode, input int k);
        case (mode)
            1: return ((k - HB) / 8 == 0) ? 8'hFF : 8'h00;
            2: return 8'hAA;
            default: return 8'h00;
        endcase
    endfunction

    // One line of n samples starting with an h_fall; act = expected active
    // line index (-1: no writes); vpos = sample carrying a v_fall (-1: none).
    task automatic run_line(input int n, input int mode, input int act,
                            input int vpos, input bit err_exp);
        int   cut;
        logic ew;
        cut = (vpos >= 0) ? vpos : n;
        for (int k = 0; k < n; k++) begin
            pix_en     = 1'b1;
            horz_drive = (k == 0) ? 1'b0 : 1'b1;
            vert_drive = (k == vpos) ? 1'b0 : 1'b1;
            video      = vid(mode, k);
            @(posedge clk);
            #1;
            ew = (act >= 0) && (k < cut) && (k >= HB) && (k < HB + AWP)
              && ((k - HB) % 8 == 7);
            chk("wr_en", 32'(wr_en), 32'(ew));
            if (wr_en) writes++;
            if (ew) begin
                chk("wr_addr", 32'(wr_addr), act * (AWP / 8) + (k - HB) / 8);
                chk("wr_data", 32'(wr_data), 32'(exp_byte(mode, k)));
            end
            chk("frame_done", 32'(frame_done),
                32'((act == AH - 1) && (k == HB + AWP - 1) && (k < cut)));
            chk("frame_err", 32'(frame_err), 32'(err_exp && (k == vpos)));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(wr_data), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(frame_err), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_line_len"}, 32'(line_len), 0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 0);
    endtask

    task automatic chk_stats(input string tag, input int len_exp,
                             input int ecnt_exp);
`ifdef PET_VIDCAP_STATS_EN
        chk({tag, "_line_len"}, 32'(line_len), len_exp);
        chk({tag, "_err_cnt"}, 32'(err_cnt), ecnt_exp);
`else
        chk({tag, "_line_len"}, 32'(line_len), 32'(len_exp & 0));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ecnt_exp & 0));
`endif
    endtask

    initial begin
        // reset state
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        reset_n = 1'b1;

        // SEARCH ignores lit lines
        run_line(60, 3, -1, -1, 1'b0);
        run_line(60, 3, -1, -1, 1'b0);
        chk("locked_init", 32'(locked), 0);

        // frame 1: v_fall coincident with h_fall, then nominal 400-px lines
        run_line(60, 3, -1, 0, 1'b0);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        writes = 0;
        for (int i = 0; i < AH; i++) run_line(400, 1, i, -1, 1'b0);
        chk("f1_writes", writes, AH * (AWP / 8));
        chk("f1_locked", 32'(locked), 1);
        chk_stats("f1", 400, 0);

        // frame 2: v_fall mid-line, 0xAA pattern, short line 5
        run_line(60, 3, -1, 5, 1'b0);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        writes = 0;
        for (int i = 0; i < 5; i++) run_line(400, 2, i, -1, 1'b0);
        run_line(100, 2, 5, -1, 1'b0);
        run_line(400, 2, 6, -1, 1'b0);
        chk_stats("f2_short", 100, 0);
        run_line(400, 2, 7, -1, 1'b0);
        chk("f2_writes", writes, (AH - 1) * (AWP / 8) + 7);
        chk("f2_locked", 32'(locked), 1);

        // frame 3: premature v_fall on active line 3, then recovery
        run_line(60, 3, -1, 0, 1'b0);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        for (int i = 0; i < 3; i++) run_line(400, 1, i, -1, 1'b0);
        run_line(400, 1, 3, 200, 1'b1);
        chk("f3_locked", 32'(locked), 0);
        chk_stats("f3_err", 400, 1);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        for (int i = 0; i < AH; i++) run_line(400, 2, i, -1, 1'b0);
        chk("f3_relock", 32'(locked), 1);

        // frame 4: reset for one cycle mid-line
        run_line(60, 3, -1, 0, 1'b0);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        run_line(400, 1, 0, -1, 1'b0);
        run_line(400, 1, 1, -1, 1'b0);
        run_line(150, 1, 2, -1, 1'b0);
        reset_n    = 1'b0;
        pix_en     = 1'b1;
        horz_drive = 1'b1;
        vert_drive = 1'b1;
        video      = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        reset_n = 1'b1;
        repeat (3) run_line(400, 1, -1, -1, 1'b0);
        run_line(60, 3, -1, 0, 1'b0);
        repeat (VB - 1) run_line(60, 3, -1, -1, 1'b0);
        run_line(400, 1, 0, -1, 1'b0);
        chk("f4_locked", 32'(locked), 0);

        pix_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pet_vidcap.md
# pet_vidcap

Video capture receiver for the PET video chain: consumes the serial pixel stream plus horizontal and vertical drive produced by the PET video timing logic and recovers the 320×200 active raster. It tracks line and pixel position from the drive edges, deserialises pixels into bytes, and issues byte writes into a 40×200 frame buffer. It sits between the PET video generator and the display/frame-buffer side.

## Interface

Parameters:
- `H_BACKPORCH`, 40: `pix_en` samples from the `horz_drive` falling edge to the first active pixel.
- `V_BACKPORCH`, 20: `horz_drive` falling edges after the `vert_drive` falling edge before active line 0.
- `ACTIVE_W`, 320: active pixels per line; must be a multiple of 8.
- `ACTIVE_H`, 200: active lines per frame.

Ports:
- `clk` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `pix_en` in 1: pixel strobe; inputs are sampled only on cycles where `pix_en`=1.
- `video` in 1: serial pixel; 1 = lit.
- `horz_drive` in 1: horizontal sync, asserted low.
- `vert_drive` in 1: vertical sync, asserted low.
- `wr_en` out 1: one-cycle byte-write strobe.
- `wr_addr` out 13: byte address = line*(ACTIVE_W/8)+byte.
- `wr_data` out 8: 8 pixels, first pixel in bit 7.
- `frame_done` out 1: one-cycle pulse after the last byte of line ACTIVE_H-1.
- `frame_err` out 1: one-cycle pulse on a premature vertical sync.
- `locked` out 1: set on `frame_done`, cleared on `frame_err`.
- `line_len` out 10: pixel count of the last complete line.
- `err_cnt` out 8: saturating count of `frame_err`.

## Operation

- Edge detect:
  - h_fall is a `horz_drive` 1→0 transition between consecutive `pix_en` samples.
  - v_fall is the same for `vert_drive`.
  - Previous-sample registers reset to 1.
- Counters:
  - px (10 bit) clears on h_fall and otherwise increments per `pix_en`, saturating at 1023.
  - ln (9 bit) clears on v_fall and increments on h_fall, saturating at 511.
- States:
  - SEARCH (reset): on v_fall, go to ARMED.
  - ARMED: when an h_fall makes ln = V_BACKPORCH, go to ACTIVE. Active line 0 is the line that begins at that edge.
  - ACTIVE:
    - Capture on every active line.
    - After the final write of active line ACTIVE_H-1, pulse `frame_done`, set `locked`, and go to SEARCH.
    - A v_fall here pulses `frame_err`, clears `locked`, and goes to ARMED with ln=0. The partial frame is abandoned and already-written bytes are not undone.
- Capture:
  - Capture runs only in ACTIVE for pixels with H_BACKPORCH ≤ px < H_BACKPORCH+ACTIVE_W.
  - `video` shifts MSB-first into an 8-bit register.
  - On the 8th pixel of each byte, the write is issued.
  - An h_fall arriving mid-line discards the partial byte. Remaining bytes of that line are not written; the active-line index still advances.
- Simultaneous h_fall and v_fall: v_fall has priority. ln=0, the h_fall is not counted, and px clears.
- Outputs: all outputs are 0 while `reset_n`=0. Reset mid-frame returns to SEARCH with no further writes.

## Timing

- `wr_en`/`wr_addr`/`wr_data` are registered and valid the `clk` cycle after the `pix_en` sample carrying the byte's 8th pixel. They are held for exactly one cycle.
- `frame_done` is asserted the same cycle as the last `wr_en` of the frame.
- `frame_err` is asserted the cycle after the offending v_fall sample.
- State transitions take effect the cycle after the qualifying `pix_en` sample.
- No throughput limit beyond one `pix_en` per cycle. Back-to-back `pix_en` yields `wr_en` at most every 8 cycles.

## Configuration

- `PET_VIDCAP_STATS_EN`, defined:
  - `line_len` latches the px value (pre-clear) on each h_fall.
  - `err_cnt` increments on each `frame_err`, saturating at 255.
- Not defined: `line_len` and `err_cnt` are driven constant 0. Their logic is absent, and the port list is unchanged.

## Structure

- Package `pet_vidcap_pkg`: state enum (SEARCH, ARMED, ACTIVE), `PET_VID_BYTES_PER_LINE`=40, address width 13, px/ln widths.
- Sub-module `pet_vidcap_deser`: 8-bit MSB-first shift register with bit counter, flush-on-h_fall, and a registered byte-valid output.
- FSM, counters and address generation live in `pet_vidcap`.

## Test plan

- Reset then nominal frame (v_fall, 20 lines, 200 lines of 400 px, video=1 for px 40..47 only) → writes at addresses 0,40,…,7960 carry 0xFF. All other bytes are 0x00. 8000 writes total, then `frame_done`=1 and `locked`=1.
- Pattern video alternating 1,0 from px 40 → every `wr_data`=0xAA. The first write lands 1 cycle after the sample at px 47.
- v_fall at active line 100 → `frame_err` pulses, `locked`=0, no writes until 20 more h_falls. With STATS, `err_cnt`=1.
- Short line (h_fall at px 100) on line 5 → only bytes 200..206 are written for that line and line 6 starts at address 240. With STATS, `line_len`=100.
- Simultaneous h_fall/v_fall in ARMED → ln=0 and active line 0 starts at the 20th subsequent h_fall.
- `reset_n`=0 for one cycle mid-line → all outputs 0, and no `wr_en` until the next v_fall plus 20 lines.
